// File: rtl/adc_sample_filter.sv
// ============================================================================
// adc_sample_filter : boxcar moving average over 2^LOG2_DEPTH ADC samples with
//                     hysteresis limit flag and stale-data timeout.
// Optional macro ADC_FILTER_PEAK_EN adds raw peak_max / peak_min tracking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_sample_filter #(
    parameter int LOG2_DEPTH     = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       clear,
    input  logic [7:0] thresh_hi,
    input  logic [7:0] thresh_lo,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       filled,
    output logic       over_limit,
    output logic       stale
`ifdef ADC_FILTER_PEAK_EN
    ,
    output logic [7:0] peak_max,
    output logic [7:0] peak_min
`endif
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = 8 + LOG2_DEPTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_TIMEOUT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_STALE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_buf [DEPTH];
    logic [SW-1:0]         r_sum;
    logic [SW-1:0]         w_sum_next;
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_fill_cnt;
    logic [TW-1:0]         r_tcnt;
    logic [TW-1:0]         w_tcnt_next;
    logic                  w_accept;
    logic                  w_filled_next;
    logic [7:0]            w_avg;

    // clear dominates a coincident strobe, so the sample is simply dropped
    assign w_accept      = in_valid & ~clear;
    assign w_sum_next    = r_sum + SW'(in_data) - SW'(r_buf[r_wr_ptr]);
    assign w_avg         = w_sum_next[SW-1:LOG2_DEPTH];
    assign w_filled_next = filled | (r_fill_cnt == LOG2_DEPTH'(DEPTH - 1));
    assign stale         = (r_state == S_STALE);

    always_comb begin
        w_state_next = r_state;
        w_tcnt_next  = r_tcnt;
        if (w_accept) begin
            w_tcnt_next  = '0;
            w_state_next = w_filled_next ? S_RUN : S_FILL;
        end else if (r_state != S_EMPTY) begin
            if (r_tcnt != C_TIMEOUT) begin
                w_tcnt_next = r_tcnt + 1'b1;
            end
            if (w_tcnt_next == C_TIMEOUT) begin
                w_state_next = S_STALE;
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_sum      <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_tcnt     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            filled     <= 1'b0;
            over_limit <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (clear) begin
            r_state    <= S_EMPTY;
            r_sum      <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_tcnt     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            filled     <= 1'b0;
            over_limit <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_tcnt    <= w_tcnt_next;
            out_valid <= w_accept;
            if (w_accept) begin
                r_sum           <= w_sum_next;
                r_buf[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                out_data        <= w_avg;
                filled          <= w_filled_next;
                if (!filled) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                // hysteresis judged on the value being published; set beats clear
                if (w_filled_next) begin
                    if (w_avg > thresh_hi) begin
                        over_limit <= 1'b1;
                    end else if (w_avg < thresh_lo) begin
                        over_limit <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef ADC_FILTER_PEAK_EN
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            peak_max <= 8'h00;
            peak_min <= 8'hFF;
        end else if (clear) begin
            peak_max <= 8'h00;
            peak_min <= 8'hFF;
        end else if (w_accept) begin
            if (in_data > peak_max) begin
                peak_max <= in_data;
            end
            if (in_data < peak_min) begin
                peak_min <= in_data;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_filter.sv
// ============================================================================
// tb_adc_sample_filter : table vectors, directed corner sequences and random
//                        traffic checked against a window-queue reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adc_sample_filter;

    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 1 << LOG2_DEPTH;
    localparam int TO         = 20;

    logic       sclk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       clear;
    logic [7:0] thresh_hi;
    logic [7:0] thresh_lo;
    logic [7:0] out_data;
    logic       out_valid;
    logic       filled;
    logic       over_limit;
    logic       stale;
`ifdef ADC_FILTER_PEAK_EN
    logic [7:0] peak_max;
    logic [7:0] peak_min;
`endif

    adc_sample_filter #(.LOG2_DEPTH(LOG2_DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .clear      (clear),
        .thresh_hi  (thresh_hi),
        .thresh_lo  (thresh_lo),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .filled     (filled),
        .over_limit (over_limit),
        .stale      (stale)
`ifdef ADC_FILTER_PEAK_EN
        ,
        .peak_max   (peak_max),
        .peak_min   (peak_min)
`endif
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;

    // reference model: window is a FIFO of the last DEPTH samples (zeros while filling)
    int win[$];
    int m_nacc, m_idle, m_data, m_pmax, m_pmin;
    bit m_started, m_valid, m_filled, m_over, m_stale;

    typedef struct {
        bit         v;
        logic [7:0] d;
        int         e_data;
        bit         e_valid;
        bit         e_filled;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        for (int i = 0; i < DEPTH; i++) win.push_back(0);
        m_nacc = 0; m_idle = 0; m_data = 0; m_pmax = 0; m_pmin = 255;
        m_started = 0; m_valid = 0; m_filled = 0; m_over = 0; m_stale = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        int s;
        m_valid = 0;
        if (c) begin
            model_reset();
        end else if (v) begin
            win.push_back(d);
            void'(win.pop_front());
            s = 0;
            foreach (win[i]) s += win[i];
            m_data  = s / DEPTH;
            m_valid = 1;
            if (m_nacc < DEPTH) m_nacc++;
            m_filled = (m_nacc >= DEPTH);
            if (m_filled) begin
                if (m_data > int'(thresh_hi)) m_over = 1;
                else if (m_data < int'(thresh_lo)) m_over = 0;
            end
            if (d > m_pmax) m_pmax = d;
            if (d < m_pmin) m_pmin = d;
            m_idle = 0; m_stale = 0; m_started = 1;
        end else if (m_started) begin
            if (m_idle < TO) m_idle++;
            if (m_idle >= TO) m_stale = 1;
        end
    endtask

    task automatic check_model();
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_data", int'(out_data), m_data);
        chk("filled", int'(filled), int'(m_filled));
        chk("over_limit", int'(over_limit), int'(m_over));
        chk("stale", int'(stale), int'(m_stale));
`ifdef ADC_FILTER_PEAK_EN
        chk("peak_max", int'(peak_max), m_pmax);
        chk("peak_min", int'(peak_min), m_pmin);
`endif
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit c);
        @(negedge sclk);
        in_valid = v; in_data = d; clear = c;
        @(posedge sclk);
        model_step(v, int'(d), c);
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        thresh_hi = 8'd255; thresh_lo = 8'd0;
        model_reset();

        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 8'd80, 10 * (i + 1), 1'b1, (i == 7)};
        tbl[8] = '{1'b1, 8'd16, 72, 1'b1, 1'b1};
        for (int i = 9; i < 16; i++) tbl[i] = '{1'b1, 8'd16, 72 - 8 * (i - 8), 1'b1, 1'b1};
        tbl[16] = '{1'b0, 8'd0, 16, 1'b0, 1'b1};

        repeat (2) @(posedge sclk);
        #1;
        check_model();
        @(negedge sclk);
        rst = 1'b0;

        // ramp, wrap and steady-state table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].d, 1'b0);
            chk("tbl_data", int'(out_data), tbl[i].e_data);
            chk("tbl_valid", int'(out_valid), int'(tbl[i].e_valid));
            chk("tbl_filled", int'(filled), int'(tbl[i].e_filled));
            chk("tbl_over", int'(over_limit), 0);
        end

        // hysteresis: set above hi, hold in band, clear below lo
        thresh_hi = 8'd100; thresh_lo = 8'd90;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'd200, 1'b0);
        chk("hyst_set", int'(over_limit), 1);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'd95, 1'b0);
        chk("hyst_band_data", int'(out_data), 95);
        chk("hyst_hold", int'(over_limit), 1);
        for (int i = 0; i < 8; i++) drive(1'b1, 8'd88, 1'b0);
        chk("hyst_low_data", int'(out_data), 88);
        chk("hyst_clear", int'(over_limit), 0);

        // timeout boundary and recovery from retained sum
        for (int i = 0; i < TO - 1; i++) drive(1'b0, 8'd0, 1'b0);
        chk("stale_before", int'(stale), 0);
        drive(1'b0, 8'd0, 1'b0);
        chk("stale_at_to", int'(stale), 1);
        drive(1'b0, 8'd0, 1'b0);
        chk("stale_hold", int'(stale), 1);
        drive(1'b1, 8'd96, 1'b0);
        chk("stale_exit", int'(stale), 0);
        chk("stale_resume", int'(out_data), 89);
        chk("stale_filled", int'(filled), 1);

        // clear colliding with a strobe mid-fill
        drive(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'd40, 1'b0);
        drive(1'b1, 8'd200, 1'b1);
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_data", int'(out_data), 0);
        chk("clr_filled", int'(filled), 0);
        drive(1'b1, 8'd64, 1'b0);
        chk("clr_first", int'(out_data), 8);
        chk("clr_first_filled", int'(filled), 0);

        // asynchronous reset between edges while running
        for (int i = 0; i < 8; i++) drive(1'b1, 8'd120, 1'b0);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_data", int'(out_data), 0);
        chk("arst_filled", int'(filled), 0);
        chk("arst_over", int'(over_limit), 0);
        chk("arst_stale", int'(stale), 0);
`ifdef ADC_FILTER_PEAK_EN
        chk("arst_pmax", int'(peak_max), 0);
        chk("arst_pmin", int'(peak_min), 255);
`endif
        @(negedge sclk);
        rst = 1'b0;
        drive(1'b1, 8'd5, 1'b0);
        drive(1'b1, 8'd250, 1'b0);
        chk("post_rst_data", int'(out_data), 31);
`ifdef ADC_FILTER_PEAK_EN
        chk("peak_max_val", int'(peak_max), 250);
        chk("peak_min_val", int'(peak_min), 5);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                thresh_hi = 8'($urandom_range(0, 255));
                thresh_lo = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 39) == 0) begin
                for (int k = 0; k < TO + 3; k++) drive(1'b0, 8'd0, 1'b0);
            end else begin
                drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 59) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
